// File: rtl/gpio_pkg.sv
// GPIO controller shared definitions: register offsets and the bus request bundle.
package gpio_pkg;

    localparam logic [5:0] GPIO_DIR_OFS      = 6'h00;
    localparam logic [5:0] GPIO_OUT_OFS      = 6'h04;
    localparam logic [5:0] GPIO_IN_OFS       = 6'h08;
    localparam logic [5:0] GPIO_PULLUP_OFS   = 6'h0C;
    localparam logic [5:0] GPIO_PULLDOWN_OFS = 6'h10;
    localparam logic [5:0] GPIO_RISE_EN_OFS  = 6'h14;
    localparam logic [5:0] GPIO_FALL_EN_OFS  = 6'h18;
    localparam logic [5:0] GPIO_IRQ_PEND_OFS = 6'h1C;
    localparam logic [5:0] GPIO_OUT_SET_OFS  = 6'h20;
    localparam logic [5:0] GPIO_OUT_CLR_OFS  = 6'h24;

    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } gpio_req_t;

endpackage

// File: rtl/gpio_in_filter.sv
// One pin input path: 2-FF sync, optional debounce (GPIO_DEBOUNCE_EN), prev flop, edge pulses.
// Latency: filt 2 clk after pad change (+DEBOUNCE_CYCLES with debounce); rise/fall valid while filt != prev.
// Backpressure: none, free-running every cycle.
module gpio_in_filter #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pad_in,
    output logic o_filt,
    output logic o_rise,
    output logic o_fall
);

    logic sync_meta;
    logic sync_q;
    logic filt;
    logic prev_q;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= i_pad_in;
            sync_q    <= sync_meta;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Accept the new level only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync_q == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q  <= '0;
            filt_q <= sync_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= filt;
        end
    end

    assign o_filt = filt;
    assign o_rise = filt & ~prev_q;
    assign o_fall = ~filt & prev_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Register-mapped GPIO pad controller with edge interrupts; optional input debounce via GPIO_DEBOUNCE_EN.
// Latency: bus ack/rdata 1 clk after i_req; IN 2 clk after pad change; o_irq 2 clk after the filtered edge.
// Backpressure: none, every request cycle is accepted and acked the next cycle.
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int NB_GPIO         = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [5:0]         i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_ack,
    output logic               o_irq,
    output logic [NB_GPIO-1:0] o_pad_out,
    output logic [NB_GPIO-1:0] o_pad_out_en,
    output logic [NB_GPIO-1:0] o_pad_pullup,
    output logic [NB_GPIO-1:0] o_pad_pulldown,
    input  logic [NB_GPIO-1:0] i_pad_in
);

    if (NB_GPIO < 1 || NB_GPIO > 32) begin : g_bad_nb
        $error("NB_GPIO must be in 1..32");
    end

    logic [NB_GPIO-1:0] dir_q, out_q, pullup_q, pulldown_q;
    logic [NB_GPIO-1:0] rise_en_q, fall_en_q, pend_q;
    logic [NB_GPIO-1:0] filt, rise, fall;
    logic [NB_GPIO-1:0] wd, pend_set, pend_clr;
    logic [31:0]        rd_word;
    gpio_req_t          bus_req;
    logic               wr_en;
    logic               unused_bits;

    assign bus_req     = '{we: i_we, addr: {i_addr[5:2], 2'b00}, wdata: i_wdata};
    assign wr_en       = i_req & bus_req.we;
    assign wd          = bus_req.wdata[NB_GPIO-1:0];
    assign unused_bits = ^{i_addr[1:0], i_wdata};

    for (genvar g = 0; g < NB_GPIO; g++) begin : g_pin
        gpio_in_filter #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_pad_in (i_pad_in[g]),
            .o_filt   (filt[g]),
            .o_rise   (rise[g]),
            .o_fall   (fall[g])
        );
    end

    assign pend_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign pend_clr = (wr_en && bus_req.addr == GPIO_IRQ_PEND_OFS) ? wd : '0;

    always_comb begin
        rd_word = '0;
        case (bus_req.addr)
            GPIO_DIR_OFS:      rd_word[NB_GPIO-1:0] = dir_q;
            GPIO_OUT_OFS:      rd_word[NB_GPIO-1:0] = out_q;
            GPIO_IN_OFS:       rd_word[NB_GPIO-1:0] = filt;
            GPIO_PULLUP_OFS:   rd_word[NB_GPIO-1:0] = pullup_q;
            GPIO_PULLDOWN_OFS: rd_word[NB_GPIO-1:0] = pulldown_q;
            GPIO_RISE_EN_OFS:  rd_word[NB_GPIO-1:0] = rise_en_q;
            GPIO_FALL_EN_OFS:  rd_word[NB_GPIO-1:0] = fall_en_q;
            GPIO_IRQ_PEND_OFS: rd_word[NB_GPIO-1:0] = pend_q;
            default:           rd_word = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dir_q      <= '0;
            out_q      <= '0;
            pullup_q   <= '0;
            pulldown_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            pend_q     <= '0;
            o_ack      <= 1'b0;
            o_rdata    <= '0;
            o_irq      <= 1'b0;
        end else begin
            if (wr_en) begin
                case (bus_req.addr)
                    GPIO_DIR_OFS:      dir_q      <= wd;
                    GPIO_OUT_OFS:      out_q      <= wd;
                    GPIO_PULLUP_OFS:   pullup_q   <= wd;
                    GPIO_PULLDOWN_OFS: pulldown_q <= wd;
                    GPIO_RISE_EN_OFS:  rise_en_q  <= wd;
                    GPIO_FALL_EN_OFS:  fall_en_q  <= wd;
                    GPIO_OUT_SET_OFS:  out_q      <= out_q | wd;
                    GPIO_OUT_CLR_OFS:  out_q      <= out_q & ~wd;
                    default: ;
                endcase
            end
            // A new edge outranks a simultaneous software clear of the same bit.
            pend_q  <= (pend_q & ~pend_clr) | pend_set;
            o_ack   <= i_req;
            o_rdata <= (i_req && !bus_req.we) ? rd_word : '0;
            o_irq   <= |pend_q;
        end
    end

    assign o_pad_out      = out_q;
    assign o_pad_out_en   = dir_q;
    assign o_pad_pullup   = pullup_q;
    assign o_pad_pulldown = pulldown_q & ~pullup_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboarded bench for gpio_pad_ctrl: directed bus/pad vectors, monitor checks every ack.
module tb_gpio_pad_ctrl;

    localparam int NB = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic          i_clk;
    logic          i_rst_n;
    logic          i_req;
    logic          i_we;
    logic [5:0]    i_addr;
    logic [31:0]   i_wdata;
    logic [31:0]   o_rdata;
    logic          o_ack;
    logic          o_irq;
    logic [NB-1:0] o_pad_out;
    logic [NB-1:0] o_pad_out_en;
    logic [NB-1:0] o_pad_pullup;
    logic [NB-1:0] o_pad_pulldown;
    logic [NB-1:0] i_pad_in;

    gpio_pad_ctrl #(
        .NB_GPIO         (NB),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req          (i_req),
        .i_we           (i_we),
        .i_addr         (i_addr),
        .i_wdata        (i_wdata),
        .o_rdata        (o_rdata),
        .o_ack          (o_ack),
        .o_irq          (o_irq),
        .o_pad_out      (o_pad_out),
        .o_pad_out_en   (o_pad_out_en),
        .o_pad_pullup   (o_pad_pullup),
        .o_pad_pulldown (o_pad_pulldown),
        .i_pad_in       (i_pad_in)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_req   = 0;
    int          n_ack   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected response.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_ack) begin
                n_ack++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_ack: ack with no outstanding request, rdata %h", o_rdata);
                end else begin
                    check(name_q.pop_front(), o_rdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic bus(input logic we, input logic [5:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string nm);
        i_req   = 1'b1;
        i_we    = we;
        i_addr  = a;
        i_wdata = d;
        exp_q.push_back(we ? 32'h0 : exp);
        name_q.push_back(nm);
        n_req++;
        @(posedge i_clk);
        #1;
        i_req   = 1'b0;
        i_we    = 1'b0;
        i_addr  = '0;
        i_wdata = '0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 32'h0, $sformatf("wr_%02h", a));
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string nm);
        bus(1'b0, a, 32'h0, exp, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        i_rst_n  = 1'b0;
        i_req    = 1'b0;
        i_we     = 1'b0;
        i_addr   = '0;
        i_wdata  = '0;
        i_pad_in = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ack", 32'(o_ack), 32'h0);
        check("rst_rdata", o_rdata, 32'h0);
        i_rst_n = 1'b1;
        idle(1);
        check("rst_out_en", 32'(o_pad_out_en), 32'h0);
        check("rst_irq", 32'(o_irq), 32'h0);
        check("rst_pulls", 32'({o_pad_pullup, o_pad_pulldown, o_pad_out}), 32'h0);

        for (int a = 0; a <= 6'h24; a += 4) rd(6'(a), 32'h0, $sformatf("rst_reg_%02h", a));
        rd(6'h28, 32'h0, "unmapped_28");
        rd(6'h3F, 32'h0, "unmapped_3c");

        // Back-to-back writes: output register composition.
        wr(6'h00, 32'hFF);
        wr(6'h04, 32'hA5);
        wr(6'h20, 32'h02);
        wr(6'h24, 32'h80);
        idle(1);
        check("pad_out", 32'(o_pad_out), 32'h27);
        check("pad_out_en", 32'(o_pad_out_en), 32'hFF);
        rd(6'h04, 32'h27, "out_reg");
        rd(6'h20, 32'h0, "out_set_reads0");
        rd(6'h24, 32'h0, "out_clr_reads0");
        wr(6'h00, 32'h1234_56FF);
        rd(6'h00, 32'hFF, "dir_upper_bits");
        wr(6'h28, 32'hFFFF_FFFF);
        rd(6'h28, 32'h0, "unmapped_wr");

        wr(6'h0C, 32'h0F);
        wr(6'h10, 32'hFF);
        idle(1);
        check("pullup", 32'(o_pad_pullup), 32'h0F);
        check("pulldown", 32'(o_pad_pulldown), 32'hF0);
        rd(6'h10, 32'hFF, "pulldown_reg");

        // Enabling on an already-high pin must not pend.
        i_pad_in[3] = 1'b1;
        idle(LAT + 3);
        wr(6'h14, 32'h09);
        idle(2);
        rd(6'h1C, 32'h0, "enable_no_pend");
        check("irq_idle", 32'(o_irq), 32'h0);

        // Rising edge on pin 0: IN latency, PEND, irq.
        i_pad_in[0] = 1'b1;
        idle(LAT - 1);
        rd(6'h08, 32'h08, "in_before");
        rd(6'h08, 32'h09, "in_after");
        rd(6'h1C, 32'h01, "pend_rise");
        check("irq_set", 32'(o_irq), 32'h1);
        wr(6'h1C, 32'h01);
        idle(1);
        check("irq_clr", 32'(o_irq), 32'h0);
        rd(6'h1C, 32'h0, "pend_cleared");

        // Edge coincides with W1C of the same bit.
        i_pad_in[0] = 1'b0;
        idle(LAT + 3);
        rd(6'h1C, 32'h0, "pend_no_fall");
        i_pad_in[0] = 1'b1;
        idle(LAT);
        wr(6'h1C, 32'h01);
        rd(6'h1C, 32'h01, "set_beats_w1c");
        wr(6'h1C, 32'h01);
        rd(6'h1C, 32'h0, "pend_cleared2");

        // Falling edge on pin 2.
        wr(6'h18, 32'h04);
        i_pad_in[2] = 1'b1;
        idle(LAT + 3);
        rd(6'h1C, 32'h0, "pend_no_rise2");
        i_pad_in[2] = 1'b0;
        idle(LAT + 3);
        rd(6'h1C, 32'h04, "pend_fall2");
        wr(6'h1C, 32'hFF);
        rd(6'h1C, 32'h0, "pend_cleared3");

        wr(6'h14, 32'h0B);
`ifdef GPIO_DEBOUNCE_EN
        i_pad_in[1] = 1'b1;
        idle(3);
        i_pad_in[1] = 1'b0;
        idle(LAT + 4);
        rd(6'h08, 32'h09, "glitch_in");
        rd(6'h1C, 32'h0, "glitch_pend");
        i_pad_in[1] = 1'b1;
        idle(LAT - 1);
        rd(6'h08, 32'h09, "db_in_before");
        rd(6'h08, 32'h0B, "db_in_after");
        idle(3);
        i_pad_in[1] = 1'b0;
        rd(6'h1C, 32'h02, "db_pend");
        idle(LAT + 4);
        rd(6'h08, 32'h09, "db_in_fall");
`else
        i_pad_in[1] = 1'b1;
        idle(1);
        i_pad_in[1] = 1'b0;
        idle(LAT + 3);
        rd(6'h08, 32'h09, "pulse_in");
        rd(6'h1C, 32'h02, "pulse_pend");
`endif
        check("irq_pulse", 32'(o_irq), 32'h1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge i_clk);
        idle(2);
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        check("ack_count", 32'(n_ack), 32'(n_req));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
